// File: rtl/yd_dbus_resp.sv
// yd_dbus_resp -- data-bus responder for the Yduck core.
//
// Serves the core's dbus. The bus carries a word RAM at address 0 and a small
// peripheral page at PERI_BASE. The page holds a UART transmitter with a TX
// FIFO, a UART status register and a free-running 16-bit timer.
//
// Ports
//   clk      in   1   clock, every flop on posedge
//   rst      in   1   synchronous reset, active-high
//   d_addr   in  16   word address from the core
//   d_din    in  16   write data from the core
//   d_we     in   1   write enable, the write lands at this posedge
//   d_dout   out 16   read data for d_addr, one cycle latency, read-first
//   uart_tx  out  1   8N1 serial output, LSB first, idle high
//
// Peripheral page
//   +0 UART_DATA  W: push d_din[7:0]        R: 0
//   +1 UART_STAT  R: {12'h0,ovf,full,empty,busy}   W: d_din[3]=1 clears ovf
//   +2 TIMER      R/W, increments every cycle, a write wins over the increment
module yd_dbus_resp #(
  parameter int          RAM_AW    = 10,
  parameter int          FIFO_AW   = 2,
  parameter int          BAUD_DIV  = 868,
  parameter logic [15:0] PERI_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_din,
  input  logic        d_we,
  output logic [15:0] d_dout,
  output logic        uart_tx
);

  localparam int                BW         = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]     BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0]  FIFO_DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);
  localparam logic [15:0]       STAT_ADDR  = PERI_BASE + 16'd1;
  localparam logic [15:0]       TIMER_ADDR = PERI_BASE + 16'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- address decode ----------------
  logic ram_hit, data_hit, stat_hit, timer_hit;
  assign ram_hit   = (d_addr >> RAM_AW) == 16'd0;
  assign data_hit  = d_addr == PERI_BASE;
  assign stat_hit  = d_addr == STAT_ADDR;
  assign timer_hit = d_addr == TIMER_ADDR;

  // ---------------- word RAM ----------------
  // Read and write share one block so the read sees the pre-write word.
  logic [15:0] ram [2**RAM_AW];
  logic [15:0] ram_rd_reg;

  always_ff @(posedge clk) begin
    if (d_we && ram_hit)
      ram[d_addr[RAM_AW-1:0]] <= d_din;
    ram_rd_reg <= ram[d_addr[RAM_AW-1:0]];
  end

  // ---------------- timer ----------------
  logic [15:0] timer_reg;

  always_ff @(posedge clk) begin
    if (rst)
      timer_reg <= 16'd0;
    else if (d_we && timer_hit)
      timer_reg <= d_din;
    else
      timer_reg <= timer_reg + 16'd1;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]         fifo_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               empty, full, push_req, push, pop;
  logic               ovf_reg;

  assign empty    = count_reg == '0;
  assign full     = count_reg == FIFO_DEPTH;
  assign push_req = d_we && data_hit;
  // Fullness is judged before any same-edge pop, so a pop never makes room
  // for a push on the same edge.
  assign push     = push_req && !full;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= d_din[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      if (push && !pop)
        count_reg <= count_reg + (FIFO_AW + 1)'(1);
      else if (pop && !push)
        count_reg <= count_reg - (FIFO_AW + 1)'(1);
    end
  end

  // A push and a clear cannot coincide since they target different addresses.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (push_req && full)
      ovf_reg <= 1'b1;
    else if (d_we && stat_hit && d_din[3])
      ovf_reg <= 1'b0;
  end

  // ---------------- TX FSM ----------------
  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          baud_done, busy;

  assign baud_done = baud_reg == BAUD_LAST;
  assign busy      = state_reg != IDLE;

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          state_next = START;
          baud_next  = '0;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = 3'd0;
          tx_next    = shift_reg[0];
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued frames have no gap.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'd0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  assign uart_tx = tx_reg;

  // ---------------- read path ----------------
  // The RAM output stays a bare registered read. The peripheral value and the
  // RAM select are registered beside it, and the final pick is a mux of flops.
  logic [15:0] peri_rd, peri_rd_reg;
  logic        sel_ram_reg;

  always_comb begin
    peri_rd = 16'd0;
    if (stat_hit)
      peri_rd = {12'h0, ovf_reg, full, empty, busy};
    else if (timer_hit)
      peri_rd = timer_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ram_reg <= 1'b0;
      peri_rd_reg <= 16'd0;
    end else begin
      sel_ram_reg <= ram_hit;
      peri_rd_reg <= peri_rd;
    end
  end

  assign d_dout = sel_ram_reg ? ram_rd_reg : peri_rd_reg;

endmodule

// File: tb/tb_yd_dbus_resp.sv
// tb_yd_dbus_resp -- directed and random stimulus for yd_dbus_resp, checked
// against a transaction-level model. The model holds the RAM as an array, the
// FIFO as a byte queue, the timer as load value plus elapsed edges, and the
// current UART frame as its start edge and byte.
module tb_yd_dbus_resp;
  localparam int BAUD  = 4;
  localparam int RAW   = 10;
  localparam int FRAME = 10 * BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d_addr = '0;
  logic [15:0] d_din = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_dout;
  logic        uart_tx;

  always #5 clk = ~clk;

  yd_dbus_resp #(.RAM_AW(RAW), .FIFO_AW(2), .BAUD_DIV(BAUD), .PERI_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .d_addr(d_addr), .d_din(d_din), .d_we(d_we),
    .d_dout(d_dout), .uart_tx(uart_tx)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [15:0]  mem_m [0:1023];
  bit           mem_v [0:1023];
  logic [7:0]   q_m [$];
  bit           ovf_m = 0;
  bit           act_m = 0;
  int           s_m = 0;
  logic [7:0]   cur_m = '0;
  int           e_m = 0;
  logic [15:0]  tld_v = '0;
  int           tld_e = 0;

  function automatic logic [15:0] timer_pre();
    return tld_v + 16'(e_m - 1 - tld_e);
  endfunction

  function automatic bit busy_pre();
    return act_m && (e_m - 1 - s_m) < FRAME;
  endfunction

  function automatic logic exp_tx();
    int j, k;
    if (!act_m) return 1'b1;
    j = e_m - s_m;
    if (j >= FRAME) return 1'b1;
    k = j / BAUD;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur_m[k-1];
  endfunction

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, predict, clock, compare d_dout and uart_tx.
  task automatic cyc(input bit r, input bit we, input logic [15:0] a, input logic [15:0] din);
    logic [15:0] xd;
    bit          known;
    bit          was_full;
    rst = r; d_we = we; d_addr = a; d_din = din;
    known = 1; xd = 16'd0;
    if (!r) begin
      if ((a >> RAW) == 16'd0) begin
        known = mem_v[a[9:0]];
        xd = mem_m[a[9:0]];
      end else if (a == 16'hFF01)
        xd = {12'h0, ovf_m, q_m.size() == 4, q_m.size() == 0, busy_pre()};
      else if (a == 16'hFF02)
        xd = timer_pre();
    end
    if (r) begin
      q_m.delete(); ovf_m = 0; act_m = 0; tld_v = 16'd0; tld_e = e_m;
    end else begin
      was_full = q_m.size() == 4;
      if ((!act_m || e_m - s_m >= FRAME) && q_m.size() > 0) begin
        cur_m = q_m.pop_front(); s_m = e_m; act_m = 1;
      end
      if (we && a == 16'hFF00) begin
        if (was_full) ovf_m = 1;
        else q_m.push_back(din[7:0]);
      end
      if (we && a == 16'hFF01 && din[3]) ovf_m = 0;
      if (we && a == 16'hFF02) begin tld_v = din; tld_e = e_m; end
      if (we && (a >> RAW) == 16'd0) begin mem_m[a[9:0]] = din; mem_v[a[9:0]] = 1; end
    end
    @(posedge clk); #1;
    if (known) check16("dout", d_dout, xd);
    check16("uart_tx", {15'd0, uart_tx}, {15'd0, exp_tx()});
    e_m++;
  endtask

  initial begin
    int nb, first, last, sel, rr;
    logic [15:0] ra;
    // reset
    cyc(1, 0, 16'h0000, 16'h0000);
    cyc(1, 0, 16'h0000, 16'h0000);
    check16("reset_dout", d_dout, 16'h0000);
    check16("reset_tx", {15'd0, uart_tx}, 16'h0001);
    cyc(0, 0, 16'hFF01, 16'h0000);
    check16("reset_stat", d_dout, 16'h0002);

    // 1: RAM write/read and unmapped read
    cyc(0, 1, 16'h0012, 16'hBEEF);
    cyc(0, 0, 16'h0012, 16'h0000);
    check16("t1_ram", d_dout, 16'hBEEF);
    cyc(0, 0, 16'h8000, 16'h0000);
    check16("t1_unmapped", d_dout, 16'h0000);

    // 2: single frame, busy for exactly one frame
    cyc(0, 1, 16'hFF00, 16'h0055);
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, 16'hFF01, 16'h0000);
      if (d_dout[0]) nb++;
    end
    check_int("t2_busy_cycles", nb, FRAME);

    // 3: six pushes from idle -> overflow
    for (int i = 0; i < 6; i++) cyc(0, 1, 16'hFF00, 16'(16'h10 + i));
    cyc(0, 0, 16'hFF01, 16'h0000);
    check16("t3_stat", d_dout, 16'h000D);
    cyc(0, 1, 16'hFF01, 16'h0008);
    cyc(0, 0, 16'hFF01, 16'h0000);
    check16("t3_ovf_clr", d_dout, 16'h0005);
    for (int i = 0; i < 5 * FRAME + 5; i++) cyc(0, 0, 16'h0012, 16'h0000);

    // 4: timer wrap
    cyc(0, 1, 16'hFF02, 16'hFFFF);
    cyc(0, 0, 16'hFF02, 16'h0000);
    check16("t4_timer_load", d_dout, 16'hFFFF);
    cyc(0, 0, 16'hFF02, 16'h0000);
    check16("t4_timer_wrap", d_dout, 16'h0000);

    // 5: reset mid-DATA with three bytes queued
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'hFF00, 16'(16'hC0 + i));
    for (int i = 0; i < 12; i++) cyc(0, 0, 16'h0000, 16'h0000);
    cyc(1, 0, 16'h0000, 16'h0000);
    check16("t5_tx_after_rst", {15'd0, uart_tx}, 16'h0001);
    cyc(0, 0, 16'hFF01, 16'h0000);
    check16("t5_stat", d_dout, 16'h0002);
    for (int i = 0; i < 50; i++) cyc(0, 0, 16'hFF01, 16'h0000);

    // 6: back-to-back frames
    cyc(0, 1, 16'hFF00, 16'h00A5);
    cyc(0, 1, 16'hFF00, 16'h003C);
    nb = 0; first = -1; last = -1;
    for (int i = 0; i < 90; i++) begin
      cyc(0, 0, 16'hFF01, 16'h0000);
      if (d_dout[0]) begin
        nb++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check_int("t6_busy_cycles", nb, 2 * FRAME);
    check_int("t6_busy_span", last - first + 1, 2 * FRAME);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rr = int'($urandom_range(0, 999));
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: ra = 16'($urandom_range(0, 15));
        4:          ra = 16'($urandom_range(0, 1023));
        5:          ra = 16'hFF00;
        6:          ra = 16'hFF01;
        7:          ra = 16'hFF02;
        8:          ra = 16'($urandom_range(16'h0400, 16'hFEFF));
        default:    ra = 16'($urandom_range(16'hFF03, 16'hFFFF));
      endcase
      if (rr < 3)
        cyc(1, 0, ra, 16'h0000);
      else if (sel == 5)
        cyc(0, $urandom_range(0, 1) == 1, ra, 16'($urandom));
      else
        cyc(0, $urandom_range(0, 3) == 0, ra, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
